pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage pipeline's register enables and flushes.
- Merges three stall/flush sources into one consistent set of per-stage controls:
  - the load-use/RAW hazard flag from hazard detection (ID stage),
  - branch-taken from EX,
  - the memory-ready handshake from the data-memory controller (MEM stage).
- Tracks multi-cycle memory waits with a watchdog and keeps saturating stall/flush statistics.

Parameters:
- TIMEOUT, 16, maximum MEM_WAIT cycles before mem_timeout is raised.
- STAT_W, 16, width of the statistic counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hazard_detected  input  1  ID-stage operand hazard, needs a bubble.
- branch_taken  input  1  EX-stage branch resolved taken.
- mem_r_en  input  1  EX/MEM stage instruction reads data memory.
- mem_w_en  input  1  EX/MEM stage instruction writes data memory.
- mem_ready  input  1  memory controller has completed the current access.
- stat_clr  input  1  synchronous clear of the statistic counters.
- pc_en  output  1  PC register load enable.
- if_id_en  output  1  IF/ID register enable.
- if_id_flush  output  1  IF/ID register clear to NOP.
- id_ex_en  output  1  ID/EX register enable.
- id_ex_flush  output  1  ID/EX register clear to NOP (bubble).
- ex_mem_en  output  1  EX/MEM register enable.
- mem_wb_en  output  1  MEM/WB register enable.
- mem_timeout  output  1  sticky watchdog error.
- stall_cycles  output  STAT_W  saturating count of cycles with pc_en=0.
- flush_events  output  STAT_W  saturating count of branch flushes.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - State RUN, watchdog=0, mem_timeout=0, counters=0.
  - Outputs decode combinationally from state RUN; with all inputs 0: all _en=1, both flushes=0.
- mem_access = mem_r_en | mem_w_en. Priority: memory stall > branch flush > hazard stall.
- State RUN:
  - mem_access & !mem_ready:
    - All five _en=0, both flushes=0 (full freeze, same cycle).
    - Next state MEM_WAIT, watchdog=1.
  - else branch_taken:
    - All _en=1, if_id_flush=1, id_ex_flush=1.
    - hazard_detected is ignored because the ID instruction is squashed.
    - flush_events += 1.
  - else hazard_detected:
    - pc_en=0, if_id_en=0, id_ex_flush=1.
    - ex_mem_en=1, mem_wb_en=1, id_ex_en=1.
  - else: all _en=1, no flush.
  - mem_access with mem_ready=1 in the same cycle costs zero wait cycles.
- State MEM_WAIT:
  - Outputs identical to the freeze above; branch_taken and hazard_detected are ignored because they are held stable by the frozen stages.
  - mem_ready=1: return to RUN in the same cycle.
    - Outputs are decoded as RUN using the current branch/hazard inputs, so a pending branch is applied in the release cycle.
    - Watchdog cleared.
  - mem_ready=0: watchdog increments, saturating at TIMEOUT.
    - When the watchdog equals TIMEOUT, mem_timeout sets and stays set until reset.
    - The freeze continues; the block never self-releases.
- mem_access deasserting while in MEM_WAIT is treated as mem_ready=1, a defensive release.
- Counters:
  - stall_cycles increments on every cycle with pc_en=0; flush_events increments on each RUN-state branch flush.
  - Both saturate at all-ones.
  - stat_clr has priority over increment that cycle; it does not clear mem_timeout.
- Reset asserted mid-wait: immediate return to RUN, all counters and flags cleared.
- No combinational path from mem_ready to the counters except through registered next-state logic.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT),
  - a stage-control struct bundling the five enables and two flushes,
  - the constants NOP_FLUSH and FREEZE_ALL.
- One natural sub-module: sat_counter (width-parameterised saturating counter with clear and inc), instantiated twice.

Test Plan:
- Reset with all inputs 0, then release -> all _en=1, flushes 0, counters 0, mem_timeout 0.
- hazard_detected=1 for 2 cycles -> pc_en=if_id_en=0 and id_ex_flush=1 both cycles; stall_cycles=2.
- branch_taken=1 and hazard_detected=1 in the same cycle -> if_id_flush=id_ex_flush=1, pc_en=1; flush_events=1, stall_cycles unchanged.
- mem_r_en=1, mem_ready low for 3 cycles then high:
  - All _en=0 for 3 cycles.
  - Fourth cycle all _en=1; state RUN; stall_cycles=3.
- mem_w_en=1, mem_ready=0 held 20 cycles, TIMEOUT=16:
  - mem_timeout rises after the 16th wait cycle and stays 1 after mem_ready is asserted.
  - Freeze lasts all 20 cycles.
- Branch_taken pending during a 2-cycle MEM_WAIT, then mem_ready=1 -> flushes asserted exactly in the release cycle; flush_events=1. Then stat_clr=1 -> both counters return to 0 next edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage-control patterns for the pipeline stall controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } stage_ctrl_t;

  localparam stage_ctrl_t RUN_ALL = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                      id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                      ex_mem_en: 1'b1, mem_wb_en: 1'b1};

  // Branch squash: everything advances, the two younger stages become NOPs.
  localparam stage_ctrl_t NOP_FLUSH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                        ex_mem_en: 1'b1, mem_wb_en: 1'b1};

  localparam stage_ctrl_t HAZARD_BUBBLE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                            id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1};

  localparam stage_ctrl_t FREEZE_ALL = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                         id_ex_en: 1'b0, id_ex_flush: 1'b0,
                                         ex_mem_en: 1'b0, mem_wb_en: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Merges memory-wait, branch-flush and load-use stall requests into per-stage enables/flushes.
//   state    | meaning
//   RUN      | pipeline flowing; stalls/flushes decided from current inputs
//   MEM_WAIT | data memory access outstanding; whole pipe frozen, watchdog counting
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard_detected,
  input  logic              branch_taken,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              mem_ready,
  input  logic              stat_clr,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              mem_timeout,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_t          state;
  state_t          state_next;
  logic [WD_W-1:0] wd;
  logic [WD_W-1:0] wd_next;
  logic            timeout_q;
  logic            mem_access;
  logic            freeze;
  logic            branch_flush;
  stage_ctrl_t     ctrl;

  // A dropped access while waiting releases the freeze just like mem_ready.
  assign mem_access = mem_r_en | mem_w_en;
  assign freeze     = mem_access & ~mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wd        <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      wd    <= wd_next;
      if (wd_next == WD_MAX) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = RUN;
    wd_next    = '0;
    if (freeze) begin
      state_next = MEM_WAIT;
      if (state == RUN) begin
        wd_next = WD_W'(1);
      end else begin
        wd_next = (wd == WD_MAX) ? wd : wd + 1'b1;
      end
    end
  end

  // Release from MEM_WAIT decodes like RUN, so a held branch lands in the release cycle.
  always_comb begin
    ctrl = RUN_ALL;
    if (freeze) begin
      ctrl = FREEZE_ALL;
    end else if (branch_taken) begin
      ctrl = NOP_FLUSH;
    end else if (hazard_detected) begin
      ctrl = HAZARD_BUBBLE;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign mem_timeout  = timeout_q;
  assign branch_flush = branch_taken & ~freeze;

  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (~ctrl.pc_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (branch_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: vector table plus hand sequences, expectations queued per driven cycle.
module tb_pipeline_stall_controller;

  localparam int TIMEOUT = 16;
  localparam int STAT_W  = 16;

  localparam logic [6:0] C_RUN    = 7'b1101011;
  localparam logic [6:0] C_FLUSH  = 7'b1111111;
  localparam logic [6:0] C_BUBBLE = 7'b0001111;
  localparam logic [6:0] C_FREEZE = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hazard_detected = 1'b0, branch_taken = 1'b0, mem_r_en = 1'b0;
  logic mem_w_en = 1'b0, mem_ready = 1'b0, stat_clr = 1'b0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic mem_timeout;
  logic [STAT_W-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.TIMEOUT(TIMEOUT), .STAT_W(STAT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_r_en        (mem_r_en),
    .mem_w_en        (mem_w_en),
    .mem_ready       (mem_ready),
    .stat_clr        (stat_clr),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  logic [6:0] ctrl_act;
  assign ctrl_act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit m_wait;
  int m_wd;
  bit m_to;
  int m_stall, m_flush;

  typedef struct {
    logic [6:0] ctrl;
    int         stall;
    int         flush;
    bit         to;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit         hz, br, mr, mw, rdy, clr;
    logic [6:0] ctrl;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_wait = 0; m_wd = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  // Called at posedge+1; drives one cycle, checks controls mid-cycle and stats after the edge.
  task automatic step(input bit hz, br, mr, mw, rdy, clr, input logic [6:0] cexp,
                      input string name);
    exp_t e;
    bit   frz;
    hazard_detected = hz; branch_taken = br; mem_r_en = mr;
    mem_w_en = mw; mem_ready = rdy; stat_clr = clr;
    frz = (mr | mw) & ~rdy;
    if (frz) begin
      if (!m_wait) m_wd = 1;
      else if (m_wd < TIMEOUT) m_wd++;
      if (m_wd == TIMEOUT) m_to = 1;
      m_wait = 1;
    end else begin
      m_wd = 0;
      m_wait = 0;
    end
    if (clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!cexp[6] && m_stall < (2**STAT_W - 1)) m_stall++;
      if (br && !frz && m_flush < (2**STAT_W - 1)) m_flush++;
    end
    e.ctrl = cexp; e.stall = m_stall; e.flush = m_flush; e.to = m_to;
    sb.push_back(e);
    @(negedge clk);
    check({name, ".ctrl"}, 32'(ctrl_act), 32'(sb[0].ctrl));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, ".stall_cycles"}, 32'(stall_cycles), 32'(e.stall));
      check({name, ".flush_events"}, 32'(flush_events), 32'(e.flush));
      check({name, ".mem_timeout"}, 32'(mem_timeout), 32'(e.to));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, C_RUN};
    vecs[1]  = '{1, 0, 0, 0, 1, 0, C_BUBBLE};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, C_FLUSH};
    vecs[3]  = '{1, 1, 0, 0, 0, 0, C_FLUSH};
    vecs[4]  = '{0, 0, 1, 0, 1, 0, C_RUN};
    vecs[5]  = '{1, 0, 0, 1, 1, 0, C_BUBBLE};
    vecs[6]  = '{0, 1, 1, 1, 1, 0, C_FLUSH};
    vecs[7]  = '{0, 0, 0, 1, 0, 0, C_FREEZE};
    vecs[8]  = '{1, 1, 0, 1, 0, 0, C_FREEZE};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, C_BUBBLE};
    vecs[10] = '{0, 0, 0, 0, 0, 1, C_RUN};
    vecs[11] = '{0, 1, 0, 0, 0, 1, C_FLUSH};

    model_reset();
    #12;
    check("reset.ctrl", 32'(ctrl_act), 32'(C_RUN));
    check("reset.stall_cycles", 32'(stall_cycles), 32'd0);
    check("reset.flush_events", 32'(flush_events), 32'd0);
    check("reset.mem_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset.ctrl", 32'(ctrl_act), 32'(C_RUN));

    step(1, 0, 0, 0, 0, 0, C_BUBBLE, "hazard_c1");
    step(1, 0, 0, 0, 0, 0, C_BUBBLE, "hazard_c2");
    check("hazard.stall_total", 32'(stall_cycles), 32'd2);
    step(1, 1, 0, 0, 0, 0, C_FLUSH, "branch_over_hazard");
    check("branch.flush_total", 32'(flush_events), 32'd1);
    check("branch.stall_unchanged", 32'(stall_cycles), 32'd2);
    step(0, 0, 0, 0, 0, 1, C_RUN, "clr_a");

    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, C_FREEZE, "rd_wait");
    step(0, 0, 1, 0, 1, 0, C_RUN, "rd_release");
    check("rd.stall_total", 32'(stall_cycles), 32'd3);
    step(0, 0, 0, 0, 0, 0, C_RUN, "rd_back_in_run");
    step(0, 0, 0, 0, 0, 1, C_RUN, "clr_b");

    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 1, 0, 0, C_FREEZE, "wr_wait");
      if (i == 15) check("wd.before_limit", 32'(mem_timeout), 32'd0);
      if (i == 16) check("wd.at_limit", 32'(mem_timeout), 32'd1);
    end
    step(0, 0, 0, 1, 1, 0, C_RUN, "wr_release");
    check("wd.sticky", 32'(mem_timeout), 32'd1);
    check("wr.stall_total", 32'(stall_cycles), 32'd20);
    step(0, 0, 0, 0, 0, 1, C_RUN, "clr_c");

    step(0, 1, 1, 0, 0, 0, C_FREEZE, "br_pend_w1");
    step(0, 1, 1, 0, 0, 0, C_FREEZE, "br_pend_w2");
    step(0, 1, 1, 0, 1, 0, C_FLUSH, "br_pend_release");
    check("br_pend.flush_total", 32'(flush_events), 32'd1);
    check("br_pend.stall_total", 32'(stall_cycles), 32'd2);
    step(0, 0, 0, 0, 0, 1, C_RUN, "clr_d");
    check("clr_d.stall_zero", 32'(stall_cycles), 32'd0);
    check("clr_d.flush_zero", 32'(flush_events), 32'd0);

    for (int i = 0; i < 12; i++)
      step(vecs[i].hz, vecs[i].br, vecs[i].mr, vecs[i].mw, vecs[i].rdy, vecs[i].clr,
           vecs[i].ctrl, $sformatf("vec%0d", i));

    step(1, 0, 0, 0, 0, 0, C_BUBBLE, "pre_rst_stall");
    step(0, 0, 1, 0, 0, 0, C_FREEZE, "pre_rst_w1");
    step(0, 0, 1, 0, 0, 0, C_FREEZE, "pre_rst_w2");
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midwait_rst.stall_cycles", 32'(stall_cycles), 32'd0);
    check("midwait_rst.mem_timeout", 32'(mem_timeout), 32'd0);
    mem_r_en = 1'b0;
    #1;
    check("midwait_rst.ctrl", 32'(ctrl_act), 32'(C_RUN));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, 0, 0, 0, 0, C_FLUSH, "after_rst_branch");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
